// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the 1024-word instruction memory.
// Parses SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT x 4 data bytes (MSB first)
// and, when `IMEM_LOADER_CSUM_EN is defined, a trailing XOR checksum byte.
// The core is held in reset while a frame is in flight. It is released with
// done on success or with err on a bounds or checksum failure.
// Optional feature macro: IMEM_LOADER_CSUM_EN (undefined: no checksum byte).
`timescale 1ns/1ps

module imem_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_AHI, S_ALO, S_CHI, S_CLO, S_DATA, S_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_AHI, S_ALO, S_CHI, S_CLO, S_DATA
  } state_t;
`endif

  // One past the last valid word address; start and start+count are checked against it.
  localparam logic [16:0] LIMIT = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         start_q, start_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [23:0]         shift_q, shift_d;
  logic [1:0]          bidx_q, bidx_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`else
  logic                fin_q, fin_d;
`endif

  logic                xfer;
  logic [15:0]         count_w;
  logic [16:0]         start_w;
  logic [16:0]         end_w;

  assign xfer    = in_valid & rdy_q;
  assign count_w = {cnt_q[15:8], in_data};
  assign start_w = {1'b0, start_q};
  assign end_w   = {1'b0, start_q} + {1'b0, count_w};

  assign in_ready  = rdy_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign core_hold = hold_q;
  assign done      = done_q;
  assign err       = err_q;

  // Frame parser: next state, header capture, word assembly and status flags.
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    shift_d = shift_q;
    bidx_d  = bidx_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q;
    // Every byte from ADDR_HI through the last data byte feeds the checksum.
    if (xfer && (state_q == S_AHI || state_q == S_ALO || state_q == S_CHI ||
                 state_q == S_CLO || state_q == S_DATA)) begin
      csum_d = csum_q ^ in_data;
    end
`else
    fin_d   = 1'b0;
    // Without a checksum byte, completion follows the last write strobe by one cycle.
    if (fin_q) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
`endif

    if (xfer) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == SYNC) begin
            state_d = S_AHI;
            hold_d  = 1'b1;
            err_d   = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_d  = 8'h00;
`endif
          end
        end
        S_AHI: begin
          start_d[15:8] = in_data;
          state_d       = S_ALO;
        end
        S_ALO: begin
          start_d[7:0] = in_data;
          state_d      = S_CHI;
        end
        S_CHI: begin
          cnt_d[15:8] = in_data;
          state_d     = S_CLO;
        end
        S_CLO: begin
          cnt_d  = count_w;
          cur_d  = start_q[ADDR_W-1:0];
          bidx_d = 2'd0;
          if (start_w >= LIMIT || end_w > LIMIT) begin
            // Out-of-range image: abort before any write reaches memory.
            err_d   = 1'b1;
            hold_d  = 1'b0;
            state_d = S_IDLE;
          end else if (count_w == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            maddr_d = cur_q;
            wdata_d = {shift_q, in_data};
            cur_d   = cur_q + ADDR_W'(1);
            cnt_d   = cnt_q - 16'd1;
            bidx_d  = 2'd0;
            if (cnt_q == 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_d = S_CSUM;
`else
              fin_d   = 1'b1;
              state_d = S_IDLE;
`endif
            end
          end else begin
            shift_d = {shift_q[15:0], in_data};
            bidx_d  = bidx_q + 2'd1;
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: begin
          if (in_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          hold_d  = 1'b0;
          state_d = S_IDLE;
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State register; reset returns the parser to IDLE and drops any partial frame.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output, header and word-assembly registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      shift_q <= '0;
      bidx_q  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= '0;
`else
      fin_q   <= 1'b0;
`endif
    end else begin
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      shift_q <= shift_d;
      bidx_q  <= bidx_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
`else
      fin_q   <= fin_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frame table plus cycle-exact sequences for imem_loader.
// Builds for either setting of IMEM_LOADER_CSUM_EN.
`timescale 1ns/1ps

module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;

  always #5 clk1 = ~clk1;

  imem_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Write and done capture, sampled mid-cycle.
  logic [ADDR_W-1:0] wq_a [$];
  logic [31:0]       wq_d [$];
  int                done_cnt = 0;

  always @(negedge clk1) begin
    if (rst_n === 1'b1) begin
      if (mem_we === 1'b1) begin
        wq_a.push_back(mem_addr);
        wq_d.push_back(mem_wdata);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  typedef struct {
    int           nb;   // header/data bytes (checksum excluded)
    logic [127:0] b;    // bytes, left-justified, first byte in the MSBs
    logic [7:0]   cs;   // checksum byte
    bit           sc;   // checksum byte follows the frame
    int           nw;   // expected number of writes
    logic [19:0]  wa;   // expected addresses, first write in the low bits
    logic [63:0]  wd;   // expected data, first write in the low bits
    bit           dn;   // expected done pulse
    bit           er;   // expected err after frame
  } row_t;

  row_t rows [$];

  function automatic row_t mk(input int nb, input logic [127:0] v, input logic [7:0] cs,
                              input bit sc, input int nw, input logic [19:0] wa,
                              input logic [63:0] wd, input bit dn, input bit er);
    row_t r;
    r.nb = nb;
    r.b  = v << (8 * (16 - nb));
    r.cs = cs;
    r.sc = sc;
    r.nw = nw;
    r.wa = wa;
    r.wd = wd;
    r.dn = dn;
    r.er = er;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk1);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  // Sends one table frame; 'gap' idle cycles (in_valid low, SYNC-valued data) follow each data byte.
  task automatic run_row(input row_t r, input int idx, input int gap);
    int w0;
    int d0;
    w0 = wq_a.size();
    d0 = done_cnt;
    for (int i = 0; i < r.nb; i++) begin
      send(r.b[127 - 8*i -: 8]);
      if (gap > 0 && i >= 5) begin
        in_data = 8'hA5;
        idle(gap);
        in_data = 8'h00;
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    if (r.sc) send(r.cs);
`endif
    idle(4);
    check($sformatf("row%0d_nwrites", idx), 32'(wq_a.size() - w0), 32'(r.nw));
    for (int k = 0; k < r.nw; k++) begin
      if (w0 + k < wq_a.size()) begin
        check($sformatf("row%0d_addr%0d", idx, k), 32'(wq_a[w0 + k]), 32'(r.wa[ADDR_W*k +: ADDR_W]));
        check($sformatf("row%0d_data%0d", idx, k), wq_d[w0 + k], r.wd[32*k +: 32]);
      end
    end
    check($sformatf("row%0d_done", idx), 32'(done_cnt - d0), 32'(r.dn));
    check($sformatf("row%0d_err", idx), 32'(err), 32'(r.er));
    check($sformatf("row%0d_hold", idx), 32'(core_hold), 32'd0);
  endtask

  initial begin
    int w0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Frame table, checksums are XOR of ADDR_HI .. last data byte.
    rows.push_back(mk(13, 128'({8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                                8'h20, 8'h02, 8'h00, 8'h0A}), 8'h1E, 1'b1, 2,
                      {10'h011, 10'h010}, {32'h2002000A, 32'h20010005}, 1'b1, 1'b0));
`ifdef IMEM_LOADER_CSUM_EN
    rows.push_back(mk(13, 128'({8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                                8'h20, 8'h02, 8'h00, 8'h0A}), 8'h00, 1'b1, 2,
                      {10'h011, 10'h010}, {32'h2002000A, 32'h20010005}, 1'b0, 1'b1));
`endif
    rows.push_back(mk(5, 128'({8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02}), 8'h00, 1'b0, 0,
                      20'h0, 64'h0, 1'b0, 1'b1));
    rows.push_back(mk(12, 128'({8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h01,
                                8'hDE, 8'hAD, 8'hBE, 8'hEF}), 8'h22, 1'b1, 1,
                      {10'h000, 10'h100}, {32'h0, 32'hDEADBEEF}, 1'b1, 1'b0));
    rows.push_back(mk(5, 128'({8'hA5, 8'h00, 8'h05, 8'h00, 8'h00}), 8'h05, 1'b1, 0,
                      20'h0, 64'h0, 1'b1, 1'b0));
    rows.push_back(mk(9, 128'({8'hA5, 8'h03, 8'hFF, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}),
                      8'hB9, 1'b1, 1, {10'h000, 10'h3FF}, {32'h0, 32'h11223344}, 1'b1, 1'b0));
    rows.push_back(mk(5, 128'({8'hA5, 8'h03, 8'hFE, 8'h00, 8'h03}), 8'h00, 1'b0, 0,
                      20'h0, 64'h0, 1'b0, 1'b1));
    rows.push_back(mk(9, 128'({8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5}),
                      8'h21, 1'b1, 1, {10'h000, 10'h020}, {32'h0, 32'hA5A5A5A5}, 1'b1, 1'b0));
    rows.push_back(mk(5, 128'({8'hA5, 8'h04, 8'h00, 8'h00, 8'h00}), 8'h00, 1'b0, 0,
                      20'h0, 64'h0, 1'b0, 1'b1));

    // Reset state.
    idle(2);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Cycle-exact walk through the reference frame.
    send(8'hA5);
    check("a_hold_after_sync", 32'(core_hold), 32'd1);
    send(8'h00); send(8'h10); send(8'h00); send(8'h02);
    send(8'h20); send(8'h01); send(8'h00);
    check("a_no_we_early", 32'(mem_we), 32'd0);
    send(8'h05);
    check("a_we0", 32'(mem_we), 32'd1);
    check("a_addr0", 32'(mem_addr), 32'h010);
    check("a_wdata0", mem_wdata, 32'h20010005);
    send(8'h20);
    check("a_we0_one_cycle", 32'(mem_we), 32'd0);
    check("a_addr0_stable", 32'(mem_addr), 32'h010);
    send(8'h02); send(8'h00); send(8'h0A);
    check("a_we1", 32'(mem_we), 32'd1);
    check("a_addr1", 32'(mem_addr), 32'h011);
    check("a_wdata1", mem_wdata, 32'h2002000A);
    check("a_hold_mid", 32'(core_hold), 32'd1);
    check("a_no_done_yet", 32'(done), 32'd0);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h1E);
`else
    idle(1);
`endif
    check("a_done", 32'(done), 32'd1);
    check("a_hold_release", 32'(core_hold), 32'd0);
    check("a_err", 32'(err), 32'd0);
    idle(1);
    check("a_done_pulse", 32'(done), 32'd0);

    // Table of whole frames.
    foreach (rows[i]) run_row(rows[i], i, 0);

    // Reset asserted after two of four data bytes.
    send(8'hA5); send(8'h00); send(8'h10); send(8'h00); send(8'h02);
    send(8'h20); send(8'h01);
    w0 = wq_a.size();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_mem_wdata", mem_wdata, 32'd0);
    check("mid_rst_hold", 32'(core_hold), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("mid_rst_no_write", 32'(wq_a.size() - w0), 32'd0);
    run_row(rows[0], 100, 0);

    // Data bytes with in_valid going 1-0-0-1.
    run_row(rows[0], 200, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
